// File: rtl/window_3x3_gen.sv
// -----------------------------------------------------------------------------
// window_3x3_gen
//
// Builds a 3x3 pixel neighbourhood from a raster-scan pixel stream for the
// downstream Sobel kernel. Two line memories hold the previous two lines and
// a 3-column shift window per row forms the taps.
//
// Ports:
//   pclk_i            pixel clock, rising edge
//   rst_i             asynchronous active-high reset
//   fsync_i           frame active (high for the whole frame)
//   rsync_i           pixel valid (contiguous within a line)
//   pdata_i           pixel value, sampled when fsync_i & rsync_i
//   fsync_o           fsync_i delayed by one cycle
//   rsync_o           high when pData1..9 hold a full interior window
//   pData1..pData9    window taps in raster order
//                     (1..3 line y-2, 4..6 line y-1, 7..9 line y;
//                      columns x-2, x-1, x left to right)
// -----------------------------------------------------------------------------
module window_3x3_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 640
) (
    input  logic                  pclk_i,
    input  logic                  rst_i,
    input  logic                  fsync_i,
    input  logic                  rsync_i,
    input  logic [DATA_WIDTH-1:0] pdata_i,
    output logic                  fsync_o,
    output logic                  rsync_o,
    output logic [DATA_WIDTH-1:0] pData1,
    output logic [DATA_WIDTH-1:0] pData2,
    output logic [DATA_WIDTH-1:0] pData3,
    output logic [DATA_WIDTH-1:0] pData4,
    output logic [DATA_WIDTH-1:0] pData5,
    output logic [DATA_WIDTH-1:0] pData6,
    output logic [DATA_WIDTH-1:0] pData7,
    output logic [DATA_WIDTH-1:0] pData8,
    output logic [DATA_WIDTH-1:0] pData9
);

    localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [1:0]       ROW_FULL = 2'd2;

    typedef logic [DATA_WIDTH-1:0] pix_t;

    // Line memories: lb1 holds line y-1, lb2 holds line y-2 (per column).
    pix_t lb1 [IMG_WIDTH];
    pix_t lb2 [IMG_WIDTH];

    logic [COL_W-1:0] col_q, col_d;
    logic [1:0]       row_q, row_d;
    logic             fsync_q;
    logic             rsync_q, rsync_d;
    pix_t             tap_q [9];
    pix_t             tap_d [9];

    logic pix_valid;
    logic line_end;
    pix_t top;
    pix_t mid;

    assign pix_valid = fsync_i & rsync_i;

    // Read-before-write: these are the old contents of the current column.
    assign top = lb2[col_q];
    assign mid = lb1[col_q];

    always_comb begin
        col_d    = col_q;
        row_d    = row_q;
        rsync_d  = 1'b0;
        tap_d    = tap_q;
        line_end = 1'b0;

        if (!fsync_i) begin
            // Frame gap: counters restart; stale buffer data is masked by row_q.
            col_d = '0;
            row_d = '0;
        end else if (rsync_i) begin
            tap_d[0] = tap_q[1];
            tap_d[1] = tap_q[2];
            tap_d[2] = top;
            tap_d[3] = tap_q[4];
            tap_d[4] = tap_q[5];
            tap_d[5] = mid;
            tap_d[6] = tap_q[7];
            tap_d[7] = tap_q[8];
            tap_d[8] = pdata_i;
            rsync_d  = (col_q >= COL_TWO) && (row_q == ROW_FULL);
            line_end = (col_q == COL_LAST);
            col_d    = line_end ? '0 : col_q + COL_W'(1);
        end else if (col_q != '0) begin
            // rsync_i dropped before the line filled: close it as a short line.
            // A line that already wrapped has col_q == 0 and is not counted twice.
            line_end = 1'b1;
            col_d    = '0;
        end

        if (line_end && (row_q != ROW_FULL)) begin
            row_d = row_q + 2'd1;
        end
    end

    always_ff @(posedge pclk_i or posedge rst_i) begin
        if (rst_i) begin
            col_q   <= '0;
            row_q   <= '0;
            fsync_q <= 1'b0;
            rsync_q <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                tap_q[i] <= '0;
            end
        end else begin
            // NOTE: all state updates are non-blocking so every flop samples
            // the pre-edge values computed in the comb block.
            col_q   <= col_d;
            row_q   <= row_d;
            fsync_q <= fsync_i;
            rsync_q <= rsync_d;
            tap_q   <= tap_d;
        end
    end

    // NOTE: the line memories have no reset so they map onto RAM; their
    // contents before two lines are written are never flagged valid.
    always_ff @(posedge pclk_i) begin
        if (pix_valid) begin
            lb2[col_q] <= mid;
            lb1[col_q] <= pdata_i;
        end
    end

    assign fsync_o = fsync_q;
    assign rsync_o = rsync_q;
    assign pData1  = tap_q[0];
    assign pData2  = tap_q[1];
    assign pData3  = tap_q[2];
    assign pData4  = tap_q[3];
    assign pData5  = tap_q[4];
    assign pData6  = tap_q[5];
    assign pData7  = tap_q[6];
    assign pData8  = tap_q[7];
    assign pData9  = tap_q[8];

endmodule

// File: tb/tb_window_3x3_gen.sv
// -----------------------------------------------------------------------------
// tb_window_3x3_gen
//
// Self-checking bench for window_3x3_gen with IMG_WIDTH=8, DATA_WIDTH=8.
// A per-column pixel-history model predicts fsync_o, rsync_o and the window
// every cycle; a scenario table adds per-frame window counts and one
// hand-derived window per scenario.
// -----------------------------------------------------------------------------
module tb_window_3x3_gen;

    localparam int DW = 8;
    localparam int IW = 8;

    logic          pclk_i = 1'b0;
    logic          rst_i;
    logic          fsync_i;
    logic          rsync_i;
    logic [DW-1:0] pdata_i;
    logic          fsync_o;
    logic          rsync_o;
    logic [DW-1:0] pData1, pData2, pData3, pData4, pData5;
    logic [DW-1:0] pData6, pData7, pData8, pData9;

    window_3x3_gen #(
        .DATA_WIDTH(DW),
        .IMG_WIDTH (IW)
    ) dut (
        .pclk_i (pclk_i),
        .rst_i  (rst_i),
        .fsync_i(fsync_i),
        .rsync_i(rsync_i),
        .pdata_i(pdata_i),
        .fsync_o(fsync_o),
        .rsync_o(rsync_o),
        .pData1 (pData1),
        .pData2 (pData2),
        .pData3 (pData3),
        .pData4 (pData4),
        .pData5 (pData5),
        .pData6 (pData6),
        .pData7 (pData7),
        .pData8 (pData8),
        .pData9 (pData9)
    );

    always #5 pclk_i = ~pclk_i;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: for each column, the pixels most recently written
    // there (newest last). A valid pixel's column snapshot is
    // {two-lines-up, one-line-up, itself}; the window is the last three.
    // ------------------------------------------------------------------
    typedef logic [DW-1:0] pixq_t[$];
    typedef struct {
        logic [DW-1:0] top, mid, bot;
        bit            top_k, mid_k;
    } snap_t;

    pixq_t hist [IW];
    snap_t m_snaps[$];
    int    m_col;
    int    m_rows;
    bit    m_prev_r;
    bit    m_fsync_o;
    bit    m_rsync_o;

    function automatic void model_reset();
        snap_t z;
        z.top = '0; z.mid = '0; z.bot = '0; z.top_k = 1'b1; z.mid_k = 1'b1;
        m_snaps = {};
        for (int i = 0; i < 3; i++) m_snaps.push_back(z);
        m_col     = 0;
        m_rows    = 0;
        m_prev_r  = 1'b0;
        m_fsync_o = 1'b0;
        m_rsync_o = 1'b0;
    endfunction

    function automatic void line_done();
        m_col = 0;
        if (m_rows < 2) m_rows++;
    endfunction

    function automatic void model_step(input bit f, input bit r, input logic [DW-1:0] d);
        m_fsync_o = f;
        m_rsync_o = 1'b0;
        if (!f) begin
            m_col  = 0;
            m_rows = 0;
        end else if (r) begin
            snap_t s;
            int    n = hist[m_col].size();
            s.bot   = d;
            s.mid_k = (n >= 1);
            s.top_k = (n >= 2);
            s.mid   = (n >= 1) ? hist[m_col][n-1] : '0;
            s.top   = (n >= 2) ? hist[m_col][n-2] : '0;
            hist[m_col].push_back(d);
            if (hist[m_col].size() > 2) void'(hist[m_col].pop_front());
            m_snaps.push_back(s);
            void'(m_snaps.pop_front());
            m_rsync_o = (m_col >= 2) && (m_rows == 2);
            m_col++;
            if (m_col == IW) line_done();
        end else if (m_prev_r && m_col != 0) begin
            line_done();
        end
        m_prev_r = r;
    endfunction

    // Window counting for the scenario table.
    int            win_cnt;
    int            cap_idx;
    logic [71:0]   cap_win;

    function automatic logic [71:0] dut_win();
        return {pData1, pData2, pData3, pData4, pData5, pData6, pData7, pData8, pData9};
    endfunction

    task automatic compare_outputs();
        logic [71:0] exp_w, mask;
        logic [7:0]  kt, km;
        snap_t a, b, c;
        a = m_snaps[0]; b = m_snaps[1]; c = m_snaps[2];
        kt = {8{1'b1}};
        km = {8{1'b1}};
        exp_w = {a.top, b.top, c.top, a.mid, b.mid, c.mid, a.bot, b.bot, c.bot};
        mask  = {a.top_k ? kt : 8'h00, b.top_k ? kt : 8'h00, c.top_k ? kt : 8'h00,
                 a.mid_k ? km : 8'h00, b.mid_k ? km : 8'h00, c.mid_k ? km : 8'h00,
                 24'hffffff};
        check("fsync_o", 72'(fsync_o), 72'(m_fsync_o));
        check("rsync_o", 72'(rsync_o), 72'(m_rsync_o));
        check("window", dut_win() & mask, exp_w & mask);
        if (rsync_o) begin
            if (win_cnt == cap_idx) cap_win = dut_win();
            win_cnt++;
        end
    endtask

    task automatic step(input bit f, input bit r, input logic [DW-1:0] d);
        @(negedge pclk_i);
        fsync_i = f;
        rsync_i = r;
        pdata_i = d;
        @(posedge pclk_i);
        if (rst_i) model_reset();
        else       model_step(f, r, d);
        #1;
        compare_outputs();
    endtask

    // Drive one frame of 6 lines; pixel value is 16*y + x.
    task automatic run_frame(input int len0, input int len2, input int gap);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 8'h00);
        for (int y = 0; y < 6; y++) begin
            int len;
            len = (y == 0) ? len0 : (y == 2) ? len2 : IW;
            for (int x = 0; x < len; x++) step(1'b1, 1'b1, 8'(16 * y + x));
            if (y < 5) for (int g = 0; g < gap; g++) step(1'b1, 1'b0, 8'h00);
        end
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
    endtask

    typedef struct {
        string       name;
        int          len0;
        int          len2;
        int          gap;
        int          cap_idx;
        int          exp_cnt;
        logic [71:0] exp_win;
    } scen_t;

    scen_t tbl[5];

    task automatic run_scen(input scen_t s);
        win_cnt = 0;
        cap_idx = s.cap_idx;
        cap_win = '0;
        run_frame(s.len0, s.len2, s.gap);
        check({s.name, "_count"}, 72'(win_cnt), 72'(s.exp_cnt));
        check({s.name, "_window"}, cap_win, s.exp_win);
    endtask

    initial begin
        bit f, r;

        tbl[0] = '{"continuous",  8, 8, 0, 0, 24, 72'h00_01_02_10_11_12_20_21_22};
        tbl[1] = '{"second_frame", 8, 8, 0, 0, 24, 72'h00_01_02_10_11_12_20_21_22};
        tbl[2] = '{"line_gaps",   8, 8, 3, 0, 24, 72'h00_01_02_10_11_12_20_21_22};
        tbl[3] = '{"short_line",  8, 5, 1, 3, 21, 72'h10_11_12_20_21_22_30_31_32};
        tbl[4] = '{"overlong",   10, 8, 0, 0, 24, 72'h00_01_02_08_09_10_16_17_20};

        win_cnt = 0;
        cap_idx = -1;
        cap_win = '0;
        rst_i   = 1'b1;
        fsync_i = 1'b0;
        rsync_i = 1'b0;
        pdata_i = '0;
        model_reset();
        @(posedge pclk_i);
        #1;
        compare_outputs();
        @(negedge pclk_i);
        rst_i = 1'b0;

        for (int i = 0; i < 5; i++) run_scen(tbl[i]);

        // Reset in the middle of line 3: outputs clear before the next edge.
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < IW; x++) step(1'b1, 1'b1, 8'(16 * y + x));
        for (int x = 0; x < 4; x++) step(1'b1, 1'b1, 8'(16 * 3 + x));
        check("pre_rst_rsync", 72'(rsync_o), 72'(1));
        @(negedge pclk_i);
        fsync_i = 1'b0;
        rsync_i = 1'b0;
        #2;
        rst_i = 1'b1;
        #1;
        check("rst_fsync_o", 72'(fsync_o), 72'(0));
        check("rst_rsync_o", 72'(rsync_o), 72'(0));
        check("rst_window", dut_win(), 72'(0));
        model_reset();
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 8'h00);
        @(negedge pclk_i);
        rst_i = 1'b0;
        run_scen(tbl[0]);

        // Randomised traffic, checked cycle by cycle against the model.
        cap_idx = -1;
        f = 1'b1;
        r = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) f = ~f;
            if (r) r = ($urandom_range(0, 9) != 0);
            else   r = ($urandom_range(0, 2) == 0);
            step(f, r, 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
